bresenham_stepper: RTL and testbench

- Sequential Bresenham iteration stage, directly downstream of the combinational line-parameter precompute block.
- Accepts one line's precomputed parameters (x0, x1, y0, deltax, deltay, ystep, steep) through a start/ready handshake.
- Emits one pixel coordinate per cycle to the pixel writer/framebuffer stage, with valid/ready back-pressure.
- Signals completion with a one-cycle done pulse.

---
 rtl/bresenham_stepper_if.sv | 30 +++
 rtl/bresenham_stepper.sv | 119 +++++++++++
 tb/tb_bresenham_stepper.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bresenham_stepper_if.sv
// Line-parameter load handshake and pixel output stream for bresenham_stepper.
interface bresenham_stepper_if #(
  parameter int unsigned WIDTH = 10
);
  logic             start;
  logic             in_ready;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] deltax;
  logic [WIDTH-1:0] deltay;
  logic [WIDTH-1:0] ystep;
  logic             steep;
  logic [WIDTH-1:0] pixel_x;
  logic [WIDTH-1:0] pixel_y;
  logic             pixel_valid;
  logic             pixel_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, x0, x1, y0, deltax, deltay, ystep, steep, pixel_ready,
    input  in_ready, pixel_x, pixel_y, pixel_valid, busy, done
  );

  modport slave (
    input  start, x0, x1, y0, deltax, deltay, ystep, steep, pixel_ready,
    output in_ready, pixel_x, pixel_y, pixel_valid, busy, done
  );
endinterface

// File: rtl/bresenham_stepper.sv
// Sequential Bresenham iterator: loads one precomputed line, streams one pixel per
// accepted handshake, then pulses done.
module bresenham_stepper #(
  parameter int unsigned WIDTH = 10
) (
  input logic               clk,
  input logic               rst,
  bresenham_stepper_if.slave bus
);
  localparam int unsigned EW = WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state, state_n;
  logic [WIDTH-1:0]    x, x_n, y, y_n, x_end, x_end_n;
  logic [WIDTH-1:0]    dx, dx_n, dy, dy_n, ys, ys_n;
  logic                steep_r, steep_n;
  logic signed [EW-1:0] err, err_n, t;

  logic             in_ready_q, busy_q, valid_q, done_q;
  logic [WIDTH-1:0] px_q, py_q;
  logic [WIDTH-1:0] px_n, py_n;

  // Next-state and next-output logic; outputs are registered from next values so
  // they track the state register cycle-for-cycle.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    x_end_n = x_end;
    dx_n    = dx;
    dy_n    = dy;
    ys_n    = ys;
    steep_n = steep_r;
    err_n   = err;
    t       = err - $signed({1'b0, dy});

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          x_n     = bus.x0;
          x_end_n = bus.x1;
          y_n     = bus.y0;
          dx_n    = bus.deltax;
          dy_n    = bus.deltay;
          ys_n    = bus.ystep;
          steep_n = bus.steep;
          err_n   = $signed({1'b0, bus.deltax >> 1});
          state_n = RUN;
        end
      end
      RUN: begin
        if (bus.pixel_ready) begin
          if (x == x_end) begin
            state_n = DONE;
          end else begin
            x_n = x + WIDTH'(1);
            if (t[EW-1]) begin
              y_n   = y + ys;
              err_n = t + $signed({1'b0, dx});
            end else begin
              err_n = t;
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    px_n = steep_n ? y_n : x_n;
    py_n = steep_n ? x_n : y_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      x_end      <= '0;
      dx         <= '0;
      dy         <= '0;
      ys         <= '0;
      steep_r    <= 1'b0;
      err        <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      x_end      <= x_end_n;
      dx         <= dx_n;
      dy         <= dy_n;
      ys         <= ys_n;
      steep_r    <= steep_n;
      err        <= err_n;
      in_ready_q <= (state_n == IDLE);
      busy_q     <= (state_n != IDLE);
      valid_q    <= (state_n == RUN);
      done_q     <= (state_n == DONE);
      px_q       <= px_n;
      py_q       <= py_n;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.pixel_valid = valid_q;
  assign bus.done        = done_q;
  assign bus.pixel_x     = px_q;
  assign bus.pixel_y     = py_q;
endmodule

// File: tb/tb_bresenham_stepper.sv
// Directed bench for bresenham_stepper: expected pixels queued at stimulus time,
// popped and compared on each output handshake.
module tb_bresenham_stepper;
  localparam int unsigned WIDTH = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bresenham_stepper_if #(.WIDTH(WIDTH)) bus ();
  bresenham_stepper #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int px, input int py);
    exp_q.push_back({WIDTH'(px), WIDTH'(py)});
  endtask

  function automatic logic [31:0] pix();
    return 32'({bus.pixel_x, bus.pixel_y});
  endfunction

  // Called at a falling edge; start is accepted at the next rising edge.
  task automatic drive_line(input int x0, input int x1, input int y0, input int dxv,
                            input int dyv, input int ysv, input logic st);
    bus.x0     = WIDTH'(x0);
    bus.x1     = WIDTH'(x1);
    bus.y0     = WIDTH'(y0);
    bus.deltax = WIDTH'(dxv);
    bus.deltay = WIDTH'(dyv);
    bus.ystep  = WIDTH'(ysv);
    bus.steep  = st;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.x0     = WIDTH'($urandom);
    bus.x1     = WIDTH'($urandom);
    bus.y0     = WIDTH'($urandom);
    bus.deltax = WIDTH'($urandom);
    bus.deltay = WIDTH'($urandom);
    bus.steep  = ~st;
  endtask

  // Consume the queued pixels, optionally stalling while pixel index stall_idx is shown.
  task automatic drain(input string tag, input int stall_idx, input int stall_len);
    int n = 0;
    int cyc = 0;
    int stalled = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      bus.pixel_ready = !(n == stall_idx && stalled < stall_len);
      if (!bus.pixel_ready) stalled++;
      check({tag, " valid"}, 32'(bus.pixel_valid), 32'd1);
      if (bus.pixel_valid) begin
        check({tag, " pixel"}, pix(), 32'(exp_q[0]));
        if (bus.pixel_ready) begin
          void'(exp_q.pop_front());
          n++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.pixel_ready = 1'b1;
    check({tag, " done"},      32'(bus.done),        32'd1);
    check({tag, " done valid"}, 32'(bus.pixel_valid), 32'd0);
    check({tag, " done busy"},  32'(bus.busy),        32'd1);
    check({tag, " done rdy"},   32'(bus.in_ready),    32'd0);
    @(negedge clk);
    check({tag, " post done"}, 32'(bus.done),     32'd0);
    check({tag, " post rdy"},  32'(bus.in_ready), 32'd1);
    check({tag, " post busy"}, 32'(bus.busy),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.pixel_ready = 1'b1;
    bus.x0          = '0;
    bus.x1          = '0;
    bus.y0          = '0;
    bus.deltax      = '0;
    bus.deltay      = '0;
    bus.ystep       = '0;
    bus.steep       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(bus.in_ready),    32'd1);
    check("rst busy",     32'(bus.busy),        32'd0);
    check("rst valid",    32'(bus.pixel_valid), 32'd0);
    check("rst done",     32'(bus.done),        32'd0);
    check("rst pixel",    pix(),                32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Horizontal line
    drive_line(0, 5, 0, 5, 0, 1, 1'b0);
    for (int i = 0; i <= 5; i++) push(i, 0);
    drain("horiz", -1, 0);

    // Steep line (2,1)->(4,7)
    drive_line(1, 7, 2, 6, 2, 1, 1'b1);
    push(2, 1); push(2, 2); push(3, 3); push(3, 4); push(3, 5); push(4, 6); push(4, 7);
    drain("steep", -1, 0);

    // Negative ystep
    drive_line(0, 3, 5, 3, 3, -1, 1'b0);
    push(0, 5); push(1, 4); push(2, 3); push(3, 2);
    drain("negy", -1, 0);

    // Back-pressure on (3,3) of the steep line
    drive_line(1, 7, 2, 6, 2, 1, 1'b1);
    push(2, 1); push(2, 2); push(3, 3); push(3, 4); push(3, 5); push(4, 6); push(4, 7);
    drain("stall", 2, 3);

    // Single point with a start pulse during RUN that must be ignored
    drive_line(4, 4, 9, 0, 0, 1, 1'b0);
    bus.pixel_ready = 1'b0;
    bus.x0 = WIDTH'(0); bus.x1 = WIDTH'(7); bus.y0 = WIDTH'(1);
    bus.deltax = WIDTH'(7); bus.deltay = WIDTH'(0); bus.ystep = WIDTH'(1); bus.steep = 1'b1;
    bus.start = 1'b1;
    check("point first", pix(), 32'({WIDTH'(4), WIDTH'(9)}));
    @(negedge clk);
    bus.start = 1'b0;
    check("point hold", pix(), 32'({WIDTH'(4), WIDTH'(9)}));
    push(4, 9);
    drain("point", -1, 0);
    @(negedge clk);
    check("point idle valid", 32'(bus.pixel_valid), 32'd0);
    check("point idle rdy",   32'(bus.in_ready),    32'd1);

    // Async reset while the 3rd pixel of a horizontal line is presented
    drive_line(0, 5, 0, 5, 0, 1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid pixel3", pix(), 32'({WIDTH'(2), WIDTH'(0)}));
    #2 rst = 1'b1;
    #1;
    check("rstmid valid", 32'(bus.pixel_valid), 32'd0);
    check("rstmid busy",  32'(bus.busy),        32'd0);
    check("rstmid rdy",   32'(bus.in_ready),    32'd1);
    check("rstmid done",  32'(bus.done),        32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid no done",  32'(bus.done),        32'd0);
      check("rstmid no valid", 32'(bus.pixel_valid), 32'd0);
    end
    drive_line(0, 5, 0, 5, 0, 1, 1'b0);
    for (int i = 0; i <= 5; i++) push(i, 0);
    drain("after rst", -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
